// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command decoder and its framed-byte helpers.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGetAddr = 2'd1,
    StGetData = 2'd2,
    StIssue   = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_OP  = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_OVERRUN = 2'd3;

  localparam logic [7:0] DEFAULT_WR_OPCODE = 8'h57;
  localparam logic [7:0] DEFAULT_RD_OPCODE = 8'h52;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags the terminal cycle.
module byte_timeout_timer #(
  parameter int unsigned LIMIT = 8680
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(LIMIT + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(LIMIT - 1);
  localparam logic [CntW-1:0] TermCnt = CntW'(LIMIT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != TermCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High in the cycle whose closing edge takes the count to LIMIT.
  assign expired_o = enable_i && (cnt_q == LastCnt);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Turns W/R byte frames from the UART receiver into single bus commands with error reporting.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 8680,
  parameter logic [7:0]  WR_OPCODE    = DEFAULT_WR_OPCODE,
  parameter logic [7:0]  RD_OPCODE    = DEFAULT_RD_OPCODE
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic       cmd_write_o,
  output logic [7:0] cmd_addr_o,
  output logic [7:0] cmd_wdata_o,
  output logic       err_pulse_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  state_e     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic       err_pulse_q, err_pulse_d;
  logic [1:0] err_code_q, err_code_d;

  logic in_wait;
  logic expired;
  logic handshake;
  logic decode_en;

  assign in_wait   = (state_q == StGetAddr) || (state_q == StGetData);
  assign handshake = (state_q == StIssue) && cmd_ready_i;
  // A byte arriving in the handshake cycle is the opcode of the next frame.
  assign decode_en = rx_valid_i && ((state_q == StIdle) || handshake);

  byte_timeout_timer #(
    .LIMIT(TIMEOUT_CLKS)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (in_wait),
    .clear_i  (!in_wait || rx_valid_i),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;

    unique case (state_q)
      StIdle: ;
      StGetAddr: begin
        if (rx_valid_i) begin
          cmd_d.addr = rx_data_i;
          if (cmd_q.write) begin
            state_d = StGetData;
          end else begin
            cmd_d.wdata = 8'h00;
            state_d     = StIssue;
          end
        end else if (expired) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = StIdle;
        end
      end
      StGetData: begin
        if (rx_valid_i) begin
          cmd_d.wdata = rx_data_i;
          state_d     = StIssue;
        end else if (expired) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          state_d     = StIdle;
        end
      end
      StIssue: begin
        if (cmd_ready_i) begin
          state_d = StIdle;
        end else if (rx_valid_i) begin
          err_pulse_d = 1'b1;
          err_code_d  = ERR_OVERRUN;
        end
      end
      default: state_d = StIdle;
    endcase

    if (decode_en) begin
      if (rx_data_i == WR_OPCODE) begin
        cmd_d.write = 1'b1;
        state_d     = StGetAddr;
      end else if (rx_data_i == RD_OPCODE) begin
        cmd_d.write = 1'b0;
        state_d     = StGetAddr;
      end else begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_BAD_OP;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_valid_o = (state_q == StIssue);
  assign cmd_write_o = cmd_q.write;
  assign cmd_addr_o  = cmd_q.addr;
  assign cmd_wdata_o = cmd_q.wdata;
  assign err_pulse_o = err_pulse_q;
  assign err_code_o  = err_code_q;
  assign busy_o      = (state_q != StIdle);

  property p_cmd_stable;
    @(posedge clk_i) disable iff (rst_i)
      (cmd_valid_o && !cmd_ready_i) |=> (cmd_valid_o && $stable(cmd_q));
  endproperty
  a_cmd_stable: assert property (p_cmd_stable);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder with a short timeout so the watchdog paths are reachable.
module tb_uart_cmd_decoder;

  localparam int unsigned To = 100;

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } exp_cmd_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_ready;
  logic       cmd_valid, cmd_write, err_pulse, busy;
  logic [7:0] cmd_addr, cmd_wdata;
  logic [1:0] err_code;

  int n_cmp = 0;
  int n_mis = 0;
  int hs_cnt = 0;
  int n_pushed = 0;
  int hs_before;

  exp_cmd_t   cmd_q[$];
  logic [1:0] err_q[$];

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .TIMEOUT_CLKS(To),
    .WR_OPCODE   (8'h57),
    .RD_OPCODE   (8'h52)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .cmd_valid_o(cmd_valid),
    .cmd_ready_i(cmd_ready),
    .cmd_write_o(cmd_write),
    .cmd_addr_o (cmd_addr),
    .cmd_wdata_o(cmd_wdata),
    .err_pulse_o(err_pulse),
    .err_code_o (err_code),
    .busy_o     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_cmd(input logic w, input logic [7:0] a, input logic [7:0] d);
    exp_cmd_t c;
    c.write = w;
    c.addr  = a;
    c.wdata = d;
    cmd_q.push_back(c);
    n_pushed++;
  endtask

  // Called 2 time units after a rising edge; the byte is sampled on the next edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Outputs and cmd_ready are both stable at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) begin
        if (cmd_q.size() == 0) begin
          check_eq("cmd_unexpected", {31'b0, cmd_valid}, 32'h0);
        end else begin
          check_eq("cmd_write", {31'b0, cmd_write}, {31'b0, cmd_q[0].write});
          check_eq("cmd_addr", {24'b0, cmd_addr}, {24'b0, cmd_q[0].addr});
          check_eq("cmd_wdata", {24'b0, cmd_wdata}, {24'b0, cmd_q[0].wdata});
          if (cmd_ready) begin
            void'(cmd_q.pop_front());
            hs_cnt++;
          end
        end
      end
      if (err_pulse) begin
        if (err_q.size() == 0) begin
          check_eq("err_unexpected", {31'b0, err_pulse}, 32'h0);
        end else begin
          check_eq("err_code", {30'b0, err_code}, {30'b0, err_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    cmd_ready = 1'b1;
    #12;
    check_eq("reset_outs", {12'b0, cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_pulse,
                            err_code, busy}, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(1);

    // Write frame
    send_byte(8'h57);
    check_eq("wr_busy", {31'b0, busy}, 32'h1);
    send_byte(8'h10);
    push_cmd(1'b1, 8'h10, 8'hA5);
    send_byte(8'hA5);
    check_eq("wr_latency", {31'b0, cmd_valid}, 32'h1);
    check_eq("wr_no_err", {31'b0, err_pulse}, 32'h0);
    idle(1);
    check_eq("wr_one_cycle", {31'b0, cmd_valid}, 32'h0);

    // Read frame
    push_cmd(1'b0, 8'h3C, 8'h00);
    send_byte(8'h52);
    send_byte(8'h3C);
    check_eq("rd_valid", {31'b0, cmd_valid}, 32'h1);
    check_eq("rd_busy_hs", {31'b0, busy}, 32'h1);
    idle(1);
    check_eq("rd_busy_after", {31'b0, busy}, 32'h0);

    // Bad opcode, then a good read
    err_q.push_back(2'd1);
    send_byte(8'h41);
    check_eq("badop_pulse", {31'b0, err_pulse}, 32'h1);
    check_eq("badop_code", {30'b0, err_code}, 32'h1);
    check_eq("badop_busy", {31'b0, busy}, 32'h0);
    idle(1);
    check_eq("badop_one_cycle", {31'b0, err_pulse}, 32'h0);
    check_eq("badop_code_hold", {30'b0, err_code}, 32'h1);
    push_cmd(1'b0, 8'h01, 8'h00);
    send_byte(8'h52);
    send_byte(8'h01);
    idle(2);

    // Timeout after address byte
    err_q.push_back(2'd2);
    send_byte(8'h57);
    send_byte(8'h20);
    repeat (To - 1) @(posedge clk);
    #1;
    check_eq("to_early", {31'b0, err_pulse}, 32'h0);
    check_eq("to_busy_wait", {31'b0, busy}, 32'h1);
    @(posedge clk);
    #1;
    check_eq("to_pulse", {31'b0, err_pulse}, 32'h1);
    check_eq("to_code", {30'b0, err_code}, 32'h2);
    check_eq("to_idle", {31'b0, busy}, 32'h0);
    #1;
    idle(2);

    // Byte on the terminal-count cycle is accepted
    push_cmd(1'b1, 8'h20, 8'hA5);
    send_byte(8'h57);
    send_byte(8'h20);
    repeat (To - 1) @(posedge clk);
    #2;
    send_byte(8'hA5);
    check_eq("tc_accept", {31'b0, cmd_valid}, 32'h1);
    check_eq("tc_no_err", {31'b0, err_pulse}, 32'h0);
    idle(2);

    // Back-to-back: next opcode arrives in the handshake cycle
    push_cmd(1'b0, 8'h11, 8'h00);
    push_cmd(1'b0, 8'h22, 8'h00);
    send_byte(8'h52);
    send_byte(8'h11);
    send_byte(8'h52);
    check_eq("b2b_valid_drop", {31'b0, cmd_valid}, 32'h0);
    check_eq("b2b_busy", {31'b0, busy}, 32'h1);
    send_byte(8'h22);
    idle(2);

    // Backpressure with an overrun byte mid-wait
    cmd_ready = 1'b0;
    push_cmd(1'b1, 8'h44, 8'h99);
    send_byte(8'h57);
    send_byte(8'h44);
    send_byte(8'h99);
    idle(5);
    err_q.push_back(2'd3);
    send_byte(8'h52);
    check_eq("ovr_pulse", {31'b0, err_pulse}, 32'h1);
    check_eq("ovr_code", {30'b0, err_code}, 32'h3);
    check_eq("ovr_pending", {31'b0, cmd_valid}, 32'h1);
    idle(14);
    check_eq("ovr_still_valid", {31'b0, cmd_valid}, 32'h1);
    hs_before = hs_cnt;
    cmd_ready = 1'b1;
    idle(1);
    check_eq("ovr_released", {31'b0, cmd_valid}, 32'h0);
    check_eq("ovr_single_hs", hs_cnt - hs_before, 32'h1);
    idle(1);

    // Asynchronous reset mid-frame
    send_byte(8'h57);
    send_byte(8'h10);
    check_eq("rst_pre_busy", {31'b0, busy}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_async_outs", {12'b0, cmd_valid, cmd_write, cmd_addr, cmd_wdata, err_pulse,
                                err_code, busy}, 32'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(1);
    err_q.push_back(2'd1);
    send_byte(8'hA5);
    check_eq("rst_then_badop", {30'b0, err_code}, 32'h1);
    idle(3);

    check_eq("cmd_q_drained", cmd_q.size(), 32'h0);
    check_eq("err_q_drained", err_q.size(), 32'h0);
    check_eq("hs_total", hs_cnt, n_pushed);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Sits directly downstream of the UART byte receiver and consumes its 8-bit data and single-cycle valid strobe.
- Parses a byte-stream frame: opcode, address, and for writes a data byte.
- Presents each parsed frame as one bus command to the APB master through a valid/ready handshake.
- Flags bad opcodes, inter-byte timeouts and overruns on an error strobe.

Parameters:
- TIMEOUT_CLKS, default 8680: max clk cycles allowed between bytes of a frame (10 bit-times at 868 clks/bit).
- WR_OPCODE, default 8'h57: opcode byte for write ('W').
- RD_OPCODE, default 8'h52: opcode byte for read ('R').

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver; sampled only when rx_valid=1.
- rx_valid  in  1  one-cycle strobe, one pulse per received byte.
- cmd_valid  out  1  command available.
- cmd_ready  in  1  APB master accepts the command.
- cmd_write  out  1  1=write, 0=read.
- cmd_addr  out  8  command address.
- cmd_wdata  out  8  write data; 8'h00 for reads.
- err_pulse  out  1  one-cycle error strobe.
- err_code  out  2  error cause: 1=bad opcode, 2=timeout, 3=overrun. Valid with err_pulse; holds its last value otherwise.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0, including cmd_* fields, err_code and the timeout counter.
- States and transitions:
  - IDLE: on rx_valid, if rx_data==WR_OPCODE, set write flag and go to GET_ADDR. If rx_data==RD_OPCODE, clear write flag and go to GET_ADDR. Any other byte: err_pulse with code 1, stay in IDLE.
  - GET_ADDR: on rx_valid, latch cmd_addr. For writes go to GET_DATA. For reads set cmd_wdata=0 and go to ISSUE.
  - GET_DATA: on rx_valid, latch cmd_wdata and go to ISSUE.
  - ISSUE: cmd_valid=1. cmd_write, cmd_addr and cmd_wdata stay stable until the handshake (cmd_valid & cmd_ready in the same cycle). The next cycle has cmd_valid=0 and state=IDLE.
- Latency: cmd_valid rises the cycle after the rx_valid of the final byte of the frame. With cmd_ready held high, cmd_valid is high for exactly one cycle.
- Timeout:
  - The counter runs only in GET_ADDR and GET_DATA and clears on every accepted byte and on entering those states.
  - Counter width is clog2(TIMEOUT_CLKS+1).
  - When the counter reaches TIMEOUT_CLKS with no rx_valid that cycle: err_pulse with code 2, go to IDLE, discard the partial frame.
  - rx_valid in the same cycle as the terminal count wins: the byte is accepted and no error is raised.
- Overrun: rx_valid in ISSUE while cmd_ready=0 drops the byte and raises err_pulse with code 3. The pending command is unaffected.
- Back-to-back frames: rx_valid in the handshake cycle is decoded as a new opcode, with the same rules as IDLE. The handshake still completes.
- Simultaneous errors cannot occur; at most one err_pulse per cycle.
- No output is combinationally dependent on any input; all outputs are registered.

Decomposition:
- Shared package uart_cmd_pkg:
  - state encodings IDLE/GET_ADDR/GET_DATA/ISSUE (2-bit);
  - ERR_BAD_OP=2'd1, ERR_TIMEOUT=2'd2, ERR_OVERRUN=2'd3;
  - default opcode constants.
- One sub-module, byte_timeout_timer: inputs clk, rst, enable, clear; parameter LIMIT; output expired. Reused by future framed-byte blocks.

Test Plan:
- Write frame: rx bytes 57,10,A5 with cmd_ready=1 -> one cycle after third rx_valid: cmd_valid=1 for exactly 1 cycle, cmd_write=1, cmd_addr=10, cmd_wdata=A5, no err_pulse.
- Read frame: bytes 52,3C -> cmd_valid=1, cmd_write=0, cmd_addr=3C, cmd_wdata=00. busy falls the cycle after the handshake.
- Bad opcode: byte 41 -> err_pulse one cycle, err_code=1, busy stays 0. A following 52,01 produces a read of address 01.
- Timeout, with TIMEOUT_CLKS=100:
  - bytes 57,20 then silence -> err_pulse with err_code=2 exactly 100 cycles after the 20 byte, state IDLE, no cmd_valid.
  - byte at cycle 100 -> accepted, no error.
- Backpressure/overrun: frame 57,44,99 with cmd_ready=0 for 20 cycles and byte 52 injected mid-wait -> err_code=3 pulse, fields remain 1/44/99. Raising cmd_ready gives a single handshake.
- Reset mid-frame: rst pulse after bytes 57,10 -> all outputs 0 immediately, asynchronously. Next byte A5 after release -> err_code=1.
